// File: rtl/hwce_seq_pkg.sv
// Shared types and constants for the HWCE sequencing controller.
// The output decode lives here so the FSM registers all pins from one place.
package hwce_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FILL  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int CLEAR_CYCLES = 2;
  localparam int CLR_W        = 2;

  typedef struct packed {
    logic cfg_ready;
    logic engine_clear;
    logic engine_start;
    logic x_allow;
    logic y_in_zero;
    logic busy;
    logic done;
  } ctrl_t;

  // Output levels that belong to a state; registered from the next state.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c              = '0;
    c.cfg_ready    = (s == ST_IDLE);
    c.engine_clear = (s == ST_CLEAR);
    c.engine_start = (s == ST_FILL) || (s == ST_RUN) || (s == ST_DRAIN);
    c.x_allow      = (s == ST_FILL) || (s == ST_RUN);
    c.y_in_zero    = (s == ST_FILL);
    c.busy         = (s != ST_IDLE);
    c.done         = (s == ST_DONE);
    return c;
  endfunction

endpackage

// File: rtl/hwce_beat_cnt.sv
// Handshake counter with synchronous clear and a terminal-count compare.
// at_last is high while the count sits one below the terminal value.
module hwce_beat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] term,
  output logic             at_last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_last = (count == term - WIDTH'(1));

endmodule

// File: rtl/hwce_seq_ctrl.sv
// Job sequencer for the convolution engine: clear, line-buffer fill, run,
// drain of the remaining outputs, done. Abort always passes through a clear.
module hwce_seq_ctrl
  import hwce_seq_pkg::*;
#(
  parameter int FILTER_SIZE = 5,
  parameter int DIM_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIM_WIDTH-1:0] cfg_width_i,
  input  logic [DIM_WIDTH-1:0] cfg_height_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic                 abort_i,
  output logic                 engine_start_o,
  output logic                 engine_clear_o,
  input  logic                 x_in_TVALID_i,
  input  logic                 x_in_TREADY_i,
  output logic                 x_allow_o,
  output logic                 y_in_zero_o,
  input  logic                 y_out_TVALID_i,
  input  logic                 y_out_TREADY_i,
  output logic                 y_out_TLAST_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 cfg_err_o,
  output state_t               dbg_state
);

  localparam int CW = 2 * DIM_WIDTH;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  state_t            state, state_nxt;
  ctrl_t             ctrl_q;
  logic              cfg_err_q;
  logic [CW-1:0]     fill_n, tot_n, out_n;
  logic [CW-1:0]     fill_new, tot_new, out_new, beat_term;
  logic [CLR_W-1:0]  clr_cyc;
  logic              aborting, out_done;
  logic              cfg_fire, cfg_bad;
  logic              beat_en, out_en, cnt_clr;
  logic              beat_last, out_last, beat_hit, out_hit;

  // Handshakes: a job transfers on cfg_valid_i && cfg_ready_o; x and y
  // traffic is only observed, a beat counts on TVALID && TREADY in one cycle.
  assign cfg_fire = cfg_valid_i && ctrl_q.cfg_ready;
  assign cfg_bad  = (cfg_width_i < DIM_WIDTH'(FILTER_SIZE)) ||
                    (cfg_height_i < DIM_WIDTH'(FILTER_SIZE));

  assign fill_new = CW'(FILTER_SIZE - 1) * CW'(cfg_width_i);
  assign tot_new  = CW'(cfg_width_i) * CW'(cfg_height_i);
  assign out_new  = CW'(cfg_height_i - DIM_WIDTH'(FILTER_SIZE - 1)) * CW'(cfg_width_i);

  assign beat_en = x_in_TVALID_i && x_in_TREADY_i &&
                   ((state == ST_FILL) || (state == ST_RUN));
  assign out_en  = y_out_TVALID_i && y_out_TREADY_i &&
                   ((state == ST_RUN) || (state == ST_DRAIN));
  assign cnt_clr = (state == ST_IDLE) || (state == ST_CLEAR);

  // One beat counter serves both fill and total thresholds; it never resets
  // between FILL and RUN, so the terminal value is swapped instead.
  assign beat_term = (state == ST_FILL) ? fill_n : tot_n;

  hwce_beat_cnt #(.WIDTH(CW)) u_beat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (beat_en),
    .clr     (cnt_clr),
    .term    (beat_term),
    .at_last (beat_last)
  );

  hwce_beat_cnt #(.WIDTH(CW)) u_out_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (out_en),
    .clr     (cnt_clr),
    .term    (out_n),
    .at_last (out_last)
  );

  assign beat_hit = beat_en && beat_last;
  assign out_hit  = out_en && out_last;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (cfg_fire && !cfg_bad) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_cyc == CLR_LAST) state_nxt = aborting ? ST_IDLE : ST_FILL;
      end
      ST_FILL: begin
        if (abort_i)       state_nxt = ST_CLEAR;
        else if (beat_hit) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort_i)       state_nxt = ST_CLEAR;
        else if (beat_hit) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The last output may already have landed while still in RUN.
        if (abort_i)                  state_nxt = ST_CLEAR;
        else if (out_done || out_hit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = abort_i ? ST_CLEAR : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ctrl_q    <= decode_ctrl(ST_IDLE);
      cfg_err_q <= 1'b0;
      fill_n    <= '0;
      tot_n     <= '0;
      out_n     <= '0;
      clr_cyc   <= '0;
      aborting  <= 1'b0;
      out_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ctrl_q    <= decode_ctrl(state_nxt);
      cfg_err_q <= cfg_fire && cfg_bad;
      if (cfg_fire && !cfg_bad) begin
        fill_n <= fill_new;
        tot_n  <= tot_new;
        out_n  <= out_new;
      end
      if ((state_nxt == ST_CLEAR) && (state != ST_CLEAR)) begin
        aborting <= (state != ST_IDLE);
        clr_cyc  <= '0;
      end else if (state == ST_CLEAR) begin
        clr_cyc <= clr_cyc + CLR_W'(1);
      end
      if (cnt_clr)      out_done <= 1'b0;
      else if (out_hit) out_done <= 1'b1;
    end
  end

  assign cfg_ready_o    = ctrl_q.cfg_ready;
  assign engine_clear_o = ctrl_q.engine_clear;
  assign engine_start_o = ctrl_q.engine_start;
  assign x_allow_o      = ctrl_q.x_allow;
  assign y_in_zero_o    = ctrl_q.y_in_zero;
  assign busy_o         = ctrl_q.busy;
  assign done_o         = ctrl_q.done;
  assign cfg_err_o      = cfg_err_q;
  assign y_out_TLAST_o  = y_out_TVALID_i && out_last;
  assign dbg_state      = state;

endmodule

// File: tb/tb_hwce_seq_ctrl.sv
// Bench for hwce_seq_ctrl: a job table run through an engine model whose
// pending outputs carry their expected TLAST, plus reset and abort sequences.
module tb_hwce_seq_ctrl;
  import hwce_seq_pkg::*;

  localparam int DW     = 16;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] cfg_width_i = '0, cfg_height_i = '0;
  logic          cfg_valid_i = 1'b0, abort_i = 1'b0;
  logic          x_in_TVALID_i = 1'b0, x_in_TREADY_i = 1'b0;
  logic          y_out_TVALID_i = 1'b0, y_out_TREADY_i = 1'b0;
  logic          cfg_ready_o, engine_start_o, engine_clear_o, x_allow_o, y_in_zero_o;
  logic          y_out_TLAST_o, busy_o, done_o, cfg_err_o;
  state_t        dbg_state;

  always #5 clk = ~clk;

  hwce_seq_ctrl #(.FILTER_SIZE(5), .DIM_WIDTH(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_width_i    (cfg_width_i),
    .cfg_height_i   (cfg_height_i),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .abort_i        (abort_i),
    .engine_start_o (engine_start_o),
    .engine_clear_o (engine_clear_o),
    .x_in_TVALID_i  (x_in_TVALID_i),
    .x_in_TREADY_i  (x_in_TREADY_i),
    .x_allow_o      (x_allow_o),
    .y_in_zero_o    (y_in_zero_o),
    .y_out_TVALID_i (y_out_TVALID_i),
    .y_out_TREADY_i (y_out_TREADY_i),
    .y_out_TLAST_o  (y_out_TLAST_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .cfg_err_o      (cfg_err_o),
    .dbg_state      (dbg_state)
  );

  typedef struct {
    int w; int h; bit rnd_x; bit rnd_y; bit zero_lat; int abort_at;
    int exp_err; int exp_clear; int exp_fill; int exp_run; int exp_out;
    int exp_tlast; int exp_done; int exp_drain;
  } vec_t;

  typedef struct packed {
    int err; int clear; int fill; int run; int out; int tlast;
    int done; int drain; int start_seen; int dec_err; int timeout;
  } meas_t;

  int          total = 0;
  int          bad = 0;
  logic [0:0]  exp_q[$];
  vec_t        vecs[8];
  meas_t       m;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int w, input int h, input bit rx, input bit ry,
                              input bit zl, input int ab, input int err, input int clr,
                              input int fill, input int run, input int out,
                              input int tl, input int dn, input int dr);
    vec_t v;
    v.w = w; v.h = h; v.rnd_x = rx; v.rnd_y = ry; v.zero_lat = zl; v.abort_at = ab;
    v.exp_err = err; v.exp_clear = clr; v.exp_fill = fill; v.exp_run = run;
    v.exp_out = out; v.exp_tlast = tl; v.exp_done = dn; v.exp_drain = dr;
    return v;
  endfunction

  // Issues one job and plays the engine until done, abort completion or reject.
  task automatic run_job(input vec_t v, output meas_t r);
    int fill_model, out_model, beat_idx, pushed, cyc, stop_at;
    bit aborted, ab, xv, yv, yv_lat, yr, beat;
    logic [0:0] e;
    r = '0;
    fill_model = 4 * v.w;
    out_model  = (v.h - 4) * v.w;
    beat_idx = 0; pushed = 0; cyc = 0; stop_at = -1; aborted = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("cfg_ready_before_job", cfg_ready_o, 1);
    cfg_width_i    = DW'(v.w);
    cfg_height_i   = DW'(v.h);
    cfg_valid_i    = 1'b1;
    x_in_TVALID_i  = 1'b1;
    x_in_TREADY_i  = 1'b1;
    y_out_TVALID_i = 1'b0;
    y_out_TREADY_i = 1'b1;
    @(negedge clk);
    cfg_valid_i = 1'b0;
    while (1) begin
      r.clear += int'(engine_clear_o);
      r.done  += int'(done_o);
      r.err   += int'(cfg_err_o);
      if (engine_start_o) r.start_seen = 1;
      if (dbg_state == ST_DRAIN) r.drain++;
      if (cfg_ready_o !== (dbg_state == ST_IDLE) || busy_o !== (dbg_state != ST_IDLE) ||
          engine_clear_o !== (dbg_state == ST_CLEAR) ||
          engine_start_o !== (dbg_state inside {ST_FILL, ST_RUN, ST_DRAIN}) ||
          x_allow_o !== (dbg_state inside {ST_FILL, ST_RUN}) ||
          y_in_zero_o !== (dbg_state == ST_FILL) || done_o !== (dbg_state == ST_DONE))
        r.dec_err++;
      if (stop_at < 0 && (done_o || (v.exp_err != 0 && cyc >= 6) ||
                          (aborted && dbg_state == ST_IDLE)))
        stop_at = cyc + 3;
      if (stop_at >= 0 && cyc >= stop_at) break;
      if (cyc >= BUDGET) begin
        r.timeout = 1;
        break;
      end
      if (aborted) exp_q.delete();
      ab = (v.abort_at > 0) && !aborted && (dbg_state == ST_RUN) && (r.run == v.abort_at);
      xv = ab ? 1'b0 : (v.rnd_x ? 1'($urandom_range(0, 1)) : 1'b1);
      yr = v.rnd_y ? 1'($urandom_range(0, 1)) : 1'b1;
      yv_lat = (exp_q.size() > 0);
      beat = xv && x_allow_o;
      if (beat) begin
        if (dbg_state == ST_FILL) r.fill++;
        else r.run++;
        if (beat_idx >= fill_model && pushed < out_model) begin
          exp_q.push_back(1'(pushed == out_model - 1));
          pushed++;
        end
        beat_idx++;
      end
      yv = aborted ? 1'b0 : (v.zero_lat ? (exp_q.size() > 0) : yv_lat);
      abort_i        = ab;
      x_in_TVALID_i  = xv;
      y_out_TVALID_i = yv;
      y_out_TREADY_i = yr;
      if (ab) aborted = 1'b1;
      #1;
      if (yv && yr) begin
        e = exp_q.pop_front();
        check("tlast_seq", y_out_TLAST_o, e);
        r.out++;
        r.tlast += int'(y_out_TLAST_o);
      end
      @(negedge clk);
      cyc++;
    end
    abort_i = 1'b0;
    x_in_TVALID_i = 1'b0;
    y_out_TVALID_i = 1'b0;
    check("end_state_idle", dbg_state == ST_IDLE, 1);
    check("end_busy", busy_o, 0);
  endtask

  task automatic compare_job(input int idx, input vec_t v, input meas_t r);
    check($sformatf("v%0d.timeout", idx), r.timeout, 0);
    check($sformatf("v%0d.cfg_err", idx), r.err, v.exp_err);
    check($sformatf("v%0d.clear_cycles", idx), r.clear, v.exp_clear);
    check($sformatf("v%0d.fill_beats", idx), r.fill, v.exp_fill);
    check($sformatf("v%0d.run_beats", idx), r.run, v.exp_run);
    check($sformatf("v%0d.outputs", idx), r.out, v.exp_out);
    check($sformatf("v%0d.tlast_count", idx), r.tlast, v.exp_tlast);
    check($sformatf("v%0d.done_pulses", idx), r.done, v.exp_done);
    check($sformatf("v%0d.start_seen", idx), r.start_seen, (v.exp_err != 0) ? 0 : 1);
    check($sformatf("v%0d.decode", idx), r.dec_err, 0);
    if (v.exp_drain >= 0) check($sformatf("v%0d.drain_cycles", idx), r.drain, v.exp_drain);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {cfg_ready_o, engine_clear_o, engine_start_o, x_allow_o, y_in_zero_o,
                 busy_o, done_o, cfg_err_o, y_out_TLAST_o}, 9'b1_0000_0000);
    check({name, "_state"}, dbg_state == ST_IDLE, 1);
  endtask

  initial begin
    //       w  h rx ry zl abort err clr fill run out tl dn drain
    vecs[0] = mk(8, 6, 0, 0, 0, 0, 0, 2, 32, 16, 16, 1, 1, 1);
    vecs[1] = mk(8, 6, 1, 1, 0, 0, 0, 2, 32, 16, 16, 1, 1, -1);
    vecs[2] = mk(4, 10, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk(10, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk(8, 10, 0, 0, 0, 20, 0, 4, 32, 20, 20, 0, 0, 0);
    vecs[5] = mk(5, 5, 0, 0, 0, 0, 0, 2, 20, 5, 5, 1, 1, 1);
    vecs[6] = mk(8, 6, 0, 0, 1, 0, 0, 2, 32, 16, 16, 1, 1, 1);
    vecs[7] = mk(6, 7, 1, 1, 0, 0, 0, 2, 24, 18, 18, 1, 1, -1);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i], m);
      compare_job(i, vecs[i], m);
    end

    // Reset while the engine waits in DRAIN on a stalled output.
    @(negedge clk);
    cfg_width_i = DW'(8); cfg_height_i = DW'(6); cfg_valid_i = 1'b1;
    x_in_TVALID_i = 1'b1; x_in_TREADY_i = 1'b1;
    y_out_TVALID_i = 1'b0; y_out_TREADY_i = 1'b0;
    @(negedge clk);
    cfg_valid_i = 1'b0;
    for (int n = 0; n < 500 && dbg_state != ST_DRAIN; n++) begin
      y_out_TVALID_i = (dbg_state == ST_RUN);
      @(negedge clk);
    end
    check("reached_drain", dbg_state == ST_DRAIN, 1);
    y_out_TVALID_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_drain");
    @(negedge clk);
    check_reset_outputs("reset_mid_drain_held");
    y_out_TVALID_i = 1'b0;
    x_in_TVALID_i = 1'b0;
    rst_n = 1'b1;
    run_job(vecs[0], m);
    compare_job(100, vecs[0], m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hwce_seq_ctrl.md
HWCE_SEQ_CTRL -- requirements
Module: hwce_seq_ctrl

Interface
REQ-001 SHALL have parameter FILTER_SIZE, default 5, convolution window side.
REQ-002 SHALL have parameter DIM_WIDTH, default 16, width of the image width/height fields.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-005 SHALL have port cfg_width_i, input, DIM_WIDTH, row length in x_in beats.
REQ-006 SHALL have port cfg_height_i, input, DIM_WIDTH, number of rows.
REQ-007 SHALL have port cfg_valid_i / cfg_ready_o, input/output, 1 each, job handshake.
REQ-008 SHALL have port abort_i, input, 1, abandons the current job.
REQ-009 SHALL have ports engine_start_o and engine_clear_o, outputs, 1 each, driving the engine start/clear pins.
REQ-010 SHALL have ports x_in_TVALID_i and x_in_TREADY_i, inputs, 1 each, monitoring the engine x_in beat handshake.
REQ-011 SHALL have port x_allow_o, output, 1, upstream x_in valid gate.
REQ-012 SHALL have port y_in_zero_o, output, 1, forces upstream y_in data to zero.
REQ-013 SHALL have ports y_out_TVALID_i and y_out_TREADY_i, inputs, 1 each, monitoring the engine output handshake.
REQ-014 SHALL have port y_out_TLAST_o, output, 1, last-output marker.
REQ-015 SHALL have ports busy_o, done_o and cfg_err_o, outputs, 1 each, status; done_o and cfg_err_o are single-cycle pulses.

Function
REQ-016 SHALL implement the states IDLE, CLEAR, FILL, RUN, DRAIN and DONE.
REQ-017 SHALL assert cfg_ready_o only in IDLE and latch W=cfg_width_i and H=cfg_height_i when cfg_valid_i && cfg_ready_o.
REQ-018 SHALL, on acceptance with W<FILTER_SIZE or H<FILTER_SIZE, pulse cfg_err_o for one cycle and remain in IDLE.
REQ-019 SHALL, on acceptance of a legal job, register FILL_N=(FILTER_SIZE-1)*W, TOT_N=W*H and OUT_N=(H-FILTER_SIZE+1)*W at the latch, then enter CLEAR.
REQ-020 SHALL hold engine_clear_o=1 for exactly 2 cycles in CLEAR, then enter FILL.
REQ-021 SHALL hold engine_start_o=1 in FILL, RUN and DRAIN, and 0 elsewhere.
REQ-022 SHALL hold x_allow_o=1 in FILL and RUN only, and 0 elsewhere.
REQ-023 SHALL count one x beat per cycle with x_in_TVALID_i && x_in_TREADY_i, and ignore beats outside FILL and RUN.
REQ-024 SHALL hold y_in_zero_o=1 in FILL.
REQ-025 SHALL move FILL->RUN on the cycle after the FILL_N-th beat is accepted.
REQ-026 SHALL move RUN->DRAIN on the cycle after the TOT_N-th beat is accepted.
REQ-027 SHALL count one output per cycle with y_out_TVALID_i && y_out_TREADY_i in RUN or DRAIN.
REQ-028 SHALL drive y_out_TLAST_o = y_out_TVALID_i && (out_cnt==OUT_N-1), combinationally.
REQ-029 SHALL move DRAIN->DONE on the cycle after the OUT_N-th output, including when that output arrives before DRAIN is reached.
REQ-030 SHALL pulse done_o for one cycle in DONE, then return to IDLE.
REQ-031 SHALL, on abort_i in any state other than IDLE or CLEAR, enter CLEAR with a 2-cycle clear, then go to IDLE without done_o; abort_i in IDLE is ignored.
REQ-032 SHALL assert busy_o in every state except IDLE.
REQ-033 SHALL size the beat and output counters and TOT_N at 2*DIM_WIDTH bits, with no wrap within a legal job.

Reset
REQ-034 SHALL, while rst_n=0, hold state IDLE, all counters and latched values 0, all outputs 0 except cfg_ready_o=1, and y_out_TLAST_o following REQ-028.
REQ-035 SHALL treat reset asserted mid-job as a full abort, with no clear pulse and no done_o.

Structure
REQ-036 SHALL place the state enum and the CLEAR_CYCLES=2 constant in package hwce_seq_pkg.
REQ-037 SHALL implement the beat and output counters as two instances of one sub-module, hwce_beat_cnt (enable, sync clear, terminal-count compare).

Verification
REQ-038 W=8, H=6 job with every beat valid -> engine_clear_o high 2 cycles, FILL for 32 beats, RUN for 16 beats, 16 outputs counted, TLAST on the 16th, done_o 1 cycle.
REQ-039 Same job with 50% random x valid and 50% random y_out_TREADY_i -> same counts; TLAST exactly once; no beat counted while x_allow_o=0.
REQ-040 W=4, H=10 -> cfg_err_o pulse, state stays IDLE, engine_start_o stays 0.
REQ-041 abort_i raised after 20 RUN beats -> 2-cycle clear, then IDLE; no done_o; a following W=5, H=5 job completes with 5 outputs.
REQ-042 rst_n driven low mid-DRAIN -> all outputs 0 except cfg_ready_o=1; the next job runs normally.
REQ-043 The OUT_N-th output arriving in the same cycle as the TOT_N-th x beat -> one DRAIN cycle, then DONE.
